// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared byte width, default depth and launch FSM states
package uart_tx_fifo_pkg;
    localparam int UART_BYTE_W = 8;
    localparam int FIFO_DEPTH = 16;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACT  = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_CLR  = 3'd4
    } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer push port plus UART_TX launch/pacing signals
// slave  (FIFO side): takes i_Wr_En/i_Wr_Data/i_TX_Active/i_TX_Done, drives status and o_TX_DV/o_TX_Byte
// master (environment side): the mirror image
interface uart_tx_fifo_if import uart_tx_fifo_pkg::*; #(parameter int DEPTH = FIFO_DEPTH);
    logic                       i_Wr_En;
    logic [UART_BYTE_W-1:0]     i_Wr_Data;
    logic                       o_Full;
    logic                       o_Empty;
    logic [$clog2(DEPTH):0]     o_Count;
    logic                       o_Overflow;
    logic                       o_Idle;
    logic                       o_TX_DV;
    logic [UART_BYTE_W-1:0]     o_TX_Byte;
    logic                       i_TX_Active;
    logic                       i_TX_Done;
    modport slave (
        input  i_Wr_En, i_Wr_Data, i_TX_Active, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Idle, o_TX_DV, o_TX_Byte
    );
    modport master (
        output i_Wr_En, i_Wr_Data, i_TX_Active, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Idle, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH-entry byte store with count, full/empty and overflow pulse
// i_Wr_En/i_Wr_Data push (ignored while full), i_Rd_En pops, o_Rd_Data shows the head byte,
// o_Count/o_Full/o_Empty decode the stored level, o_Overflow pulses one cycle after a rejected push
module uart_byte_fifo import uart_tx_fifo_pkg::*; #(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_En,
    input  logic [UART_BYTE_W-1:0] i_Wr_Data,
    input  logic                   i_Rd_En,
    output logic [UART_BYTE_W-1:0] o_Rd_Data,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic                   o_Overflow,
    output logic [ADDR_W:0]        o_Count
);
    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    // a pop on the same edge never frees room for a push that arrived while full
    assign push = i_Wr_En && !o_Full;
    assign pop = i_Rd_En && !o_Empty;
    assign o_Full = o_Count == (ADDR_W+1)'(DEPTH);
    assign o_Empty = o_Count == '0;
    assign o_Rd_Data = mem[rd_ptr];
    always_ff @(posedge i_Clock)
        if (push) mem[wr_ptr] <= i_Wr_Data;
    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_Count <= '0;
            o_Overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(push);
            rd_ptr <= rd_ptr + ADDR_W'(pop);
            o_Count <= o_Count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            o_Overflow <= i_Wr_En && o_Full;
        end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches one UART_TX frame at a time, pacing on Active/Done
// i_Clock/i_Reset: clock and async active-high reset; bus (slave): push port, FIFO status,
// o_TX_DV/o_TX_Byte toward UART_TX and i_TX_Active/i_TX_Done back from it
module uart_tx_fifo import uart_tx_fifo_pkg::*; #(
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_tx_fifo_if.slave bus
);
    tx_state_t state;
    logic launch;
    logic [UART_BYTE_W-1:0] rd_data;
    // Done must also be low so UART_TX has returned to its own idle before the next DV
    assign launch = state == IDLE && !bus.o_Empty && !bus.i_TX_Active && !bus.i_TX_Done;
    assign bus.o_Idle = bus.o_Empty && state == IDLE && !bus.i_TX_Active;
    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Wr_En    (bus.i_Wr_En),
        .i_Wr_Data  (bus.i_Wr_Data),
        .i_Rd_En    (launch),
        .o_Rd_Data  (rd_data),
        .o_Full     (bus.o_Full),
        .o_Empty    (bus.o_Empty),
        .o_Overflow (bus.o_Overflow),
        .o_Count    (bus.o_Count)
    );
    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            state <= IDLE;
            bus.o_TX_DV <= 1'b0;
            bus.o_TX_Byte <= '0;
        end else
            case (state)
                IDLE: if (launch) begin
                    bus.o_TX_Byte <= rd_data;
                    bus.o_TX_DV <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    bus.o_TX_DV <= 1'b0;
                    state <= WAIT_ACT;
                end
                WAIT_ACT: if (bus.i_TX_Active) state <= WAIT_DONE;
                WAIT_DONE: if (bus.i_TX_Done) state <= WAIT_CLR;
                WAIT_CLR: if (!bus.i_TX_Done) state <= IDLE;
                default: begin
                    state <= IDLE;
                    bus.o_TX_DV <= 1'b0;
                end
            endcase
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo driving a behavioural UART_TX (4 clocks per bit)
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_serial = 1'b1;
    logic dv_prev = 1'b0;
    int checks = 0, errors = 0;
    int max_cnt = 0, frames = 0, dv_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo_if bus();
    uart_tx_fifo dut (.i_Clock(clk), .i_Reset(rst), .bus(bus.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        return w == 0 ? bus.o_Idle : w == 1 ? bus.i_TX_Done : bus.i_TX_Active;
    endfunction

    task automatic wait_sig(input string name, input int w, input logic v, input int limit);
        int n = 0;
        while (sig(w) !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(w) !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles waiting for %0b", name, limit, v);
        end
    endtask

    task automatic wait_quiet();
        wait_sig("wait_idle", 0, 1'b1, 2000);
        wait_sig("wait_done_low", 1, 1'b0, 2000);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic push(input logic [7:0] b, input bit expect_ok);
        bus.i_Wr_En = 1'b1;
        bus.i_Wr_Data = b;
        if (expect_ok) exp_q.push_back(b);
        @(negedge clk);
        bus.i_Wr_En = 1'b0;
    endtask

    // behavioural UART_TX: Active for the 10-bit frame, then Done high for 2 cycles
    initial begin
        logic [9:0] frame;
        bus.i_TX_Active = 1'b0;
        bus.i_TX_Done = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.o_TX_DV === 1'b1) begin
                frame = {1'b1, bus.o_TX_Byte, 1'b0};
                bus.i_TX_Active <= 1'b1;
                for (int b = 0; b < 10; b++) begin
                    tx_serial <= frame[b];
                    repeat (CPB) @(posedge clk);
                end
                bus.i_TX_Active <= 1'b0;
                bus.i_TX_Done <= 1'b1;
                repeat (2) @(posedge clk);
                bus.i_TX_Done <= 1'b0;
            end
        end
    end

    // serial line decoder and scoreboard checker
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    d[b] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                check("stop_bit", tx_serial, 1);
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL line_byte: got %0h expected nothing queued", d);
                end else
                    check("line_byte", d, exp_q.pop_front());
            end
        end
    end

    // launch protocol monitor
    always @(negedge clk) begin
        if (bus.o_TX_DV === 1'b1) begin
            check("dv_single_cycle", dv_prev, 0);
            check("dv_tx_quiet", {bus.i_TX_Active, bus.i_TX_Done}, 0);
            if (dv_prev !== 1'b1) dv_cnt <= dv_cnt + 1;
        end
        dv_prev <= bus.o_TX_DV;
        if (!rst && int'(bus.o_Count) > max_cnt) max_cnt <= int'(bus.o_Count);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_Wr_En = 1'b0;
        bus.i_Wr_Data = '0;
        // reset asserted between clock edges must act at once
        #7 rst = 1'b1;
        #1;
        check("rst_count", bus.o_Count, 0);
        check("rst_empty", bus.o_Empty, 1);
        check("rst_full", bus.o_Full, 0);
        check("rst_dv", bus.o_TX_DV, 0);
        check("rst_byte", bus.o_TX_Byte, 0);
        check("rst_ovf", bus.o_Overflow, 0);
        check("rst_idle", bus.o_Idle, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single byte
        wait_quiet();
        push(8'hA5, 1);
        check("t2_dv_not_yet", bus.o_TX_DV, 0);
        check("t2_count", bus.o_Count, 1);
        @(negedge clk);
        check("t2_dv", bus.o_TX_DV, 1);
        check("t2_byte", bus.o_TX_Byte, 8'hA5);
        @(negedge clk);
        check("t2_dv_low", bus.o_TX_DV, 0);
        wait_sig("t2_done_high", 1, 1'b1, 200);
        wait_sig("t2_done_low", 1, 1'b0, 20);
        @(negedge clk);
        check("t2_idle", bus.o_Idle, 1);
        drain("t2_drain");

        // burst of 18: 17 accepted, the last one overflows
        wait_quiet();
        for (int i = 0; i < 18; i++) begin
            push(8'(i), i < 17);
            if (i == 15) check("t3_not_full", bus.o_Full, 0);
            if (i == 16) begin
                check("t3_full", bus.o_Full, 1);
                check("t3_count16", bus.o_Count, 16);
                check("t3_no_ovf", bus.o_Overflow, 0);
            end
        end
        check("t3_ovf", bus.o_Overflow, 1);
        check("t3_count_held", bus.o_Count, 16);
        @(negedge clk);
        check("t3_ovf_pulse", bus.o_Overflow, 0);
        drain("t3_drain");

        // paced then back-to-back, wrapping the pointers
        wait_quiet();
        for (int i = 0; i < 40; i++) begin
            push(8'h40 + 8'(i), 1);
            repeat (59) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 1);
        drain("t4_drain");

        // push on the exact launch-pop edge with three bytes queued
        wait_quiet();
        push(8'hC1, 1);
        push(8'hC2, 1);
        push(8'hC3, 1);
        push(8'hC4, 1);
        check("t6_count3", bus.o_Count, 3);
        wait_sig("t6_done_high", 1, 1'b1, 200);
        wait_sig("t6_done_low", 1, 1'b0, 20);
        @(negedge clk);
        push(8'hC5, 1);
        check("t6_launch", bus.o_TX_DV, 1);
        check("t6_count_same", bus.o_Count, 3);
        check("t6_no_ovf", bus.o_Overflow, 0);
        drain("t6_drain");

        // reset while a frame is in flight
        wait_quiet();
        push(8'hD0, 1);
        for (int i = 1; i < 5; i++) push(8'hD0 + 8'(i), 0);
        wait_sig("t5_active", 2, 1'b1, 50);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_count", bus.o_Count, 0);
        check("t5_rst_empty", bus.o_Empty, 1);
        check("t5_rst_dv", bus.o_TX_DV, 0);
        check("t5_rst_byte", bus.o_TX_Byte, 0);
        check("t5_rst_idle_busy", bus.o_Idle, 0);
        @(negedge clk);
        rst = 1'b0;
        push(8'h5A, 1);
        push(8'h3C, 1);
        check("t5_count2", bus.o_Count, 2);
        wait_sig("t5_done_high", 1, 1'b1, 200);
        check("t5_held_while_busy", bus.o_Count, 2);
        drain("t5_drain");
        wait_quiet();

        check("max_count", max_cnt, 16);
        check("frames", frames, 76);
        check("dv_count", dv_cnt, 76);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
